// File: rtl/tlc_light_monitor.sv
// Safety interlock beside the traffic light controller: decodes both streets'
// lamps every clock and latches sticky fault flags for unsafe or malformed behaviour.
module tlc_light_monitor #(
  parameter int MIN_YELLOW_CYCLES = 3,
  parameter int MAX_PHASE_CYCLES  = 1000,
  parameter int CNT_W             = 16
) (
  input  logic             masterclk,
  input  logic             reset_button,
  input  logic [2:0]       mainStreetleds,
  input  logic [2:0]       sideStreetleds,
  input  logic             monitor_enable,
  input  logic             clear_faults,
  output logic             fault_onehot,
  output logic             fault_conflict,
  output logic             fault_sequence,
  output logic             fault_yellow_short,
  output logic             fault_timeout,
  output logic             fault_any,
  output logic [2:0]       last_fault_code,
  output logic [CNT_W-1:0] main_green_count
);

  typedef enum logic [1:0] {LAMP_R, LAMP_Y, LAMP_G, LAMP_ILL} lampState;

  localparam logic [CNT_W-1:0] yellowMin = CNT_W'(MIN_YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] phaseMax  = CNT_W'(MAX_PHASE_CYCLES);

  function automatic lampState decodeLamp(input logic [2:0] lamps);
    case (lamps)
      3'b100:  decodeLamp = LAMP_R;
      3'b010:  decodeLamp = LAMP_Y;
      3'b001:  decodeLamp = LAMP_G;
      default: decodeLamp = LAMP_ILL;
    endcase
  endfunction

  // Legal moves are hold, R->G, G->Y and Y->R; both states must already be legal.
  function automatic logic badStep(input lampState prevL, input lampState liveL);
    badStep = !((prevL == liveL) ||
                (prevL == LAMP_R && liveL == LAMP_G) ||
                (prevL == LAMP_G && liveL == LAMP_Y) ||
                (prevL == LAMP_Y && liveL == LAMP_R));
  endfunction

  // Yellow dwell: 1 on entry, saturating count while held, cleared otherwise.
  function automatic logic [CNT_W-1:0] nextYellow(input lampState prevL, input lampState liveL,
                                                  input logic en, input logic [CNT_W-1:0] cnt);
    if (!en || liveL != LAMP_Y)   nextYellow = '0;
    else if (prevL != LAMP_Y)     nextYellow = CNT_W'(1);
    else if (cnt < yellowMin)     nextYellow = cnt + CNT_W'(1);
    else                          nextYellow = cnt;
  endfunction

  logic [2:0]       prevMain, prevSide;
  logic             prevValid;
  logic [CNT_W-1:0] yellowMainCnt, yellowSideCnt, phaseCnt;
  logic [CNT_W-1:0] yellowMainNext, yellowSideNext, phaseNext;
  lampState         liveMainL, liveSideL, prevMainL, prevSideL;
  logic [4:0]       detect, faultsNow, faultsNext;
  logic [2:0]       codeNext;
  logic             greenDone;

  assign faultsNow = {fault_timeout, fault_yellow_short, fault_sequence,
                      fault_conflict, fault_onehot};

  always_comb begin
    liveMainL = decodeLamp(mainStreetleds);
    liveSideL = decodeLamp(sideStreetleds);
    prevMainL = decodeLamp(prevMain);
    prevSideL = decodeLamp(prevSide);

    yellowMainNext = nextYellow(prevMainL, liveMainL, monitor_enable, yellowMainCnt);
    yellowSideNext = nextYellow(prevSideL, liveSideL, monitor_enable, yellowSideCnt);

    phaseNext = '0;
    if (monitor_enable && {mainStreetleds, sideStreetleds} == {prevMain, prevSide})
      phaseNext = (phaseCnt == '1) ? phaseCnt : phaseCnt + CNT_W'(1);

    detect = '0;
    if (monitor_enable) begin
      detect[0] = (liveMainL == LAMP_ILL) || (liveSideL == LAMP_ILL);
      detect[1] = (liveMainL != LAMP_ILL) && (liveSideL != LAMP_ILL) &&
                  (liveMainL != LAMP_R) && (liveSideL != LAMP_R);
      detect[2] = prevValid &&
                  ((prevMainL != LAMP_ILL && liveMainL != LAMP_ILL && badStep(prevMainL, liveMainL)) ||
                   (prevSideL != LAMP_ILL && liveSideL != LAMP_ILL && badStep(prevSideL, liveSideL)));
      detect[3] = (prevMainL == LAMP_Y && liveMainL == LAMP_R && yellowMainCnt < yellowMin) ||
                  (prevSideL == LAMP_Y && liveSideL == LAMP_R && yellowSideCnt < yellowMin);
      detect[4] = phaseNext > phaseMax;
    end

    // A fresh detection survives a simultaneous clear; everything else is wiped.
    faultsNext = detect | (clear_faults ? 5'b0 : faultsNow);

    codeNext = clear_faults ? 3'd0 : last_fault_code;
    if      (detect[0]) codeNext = 3'd1;
    else if (detect[1]) codeNext = 3'd2;
    else if (detect[2]) codeNext = 3'd3;
    else if (detect[3]) codeNext = 3'd4;
    else if (detect[4]) codeNext = 3'd5;

    greenDone = monitor_enable && prevMainL == LAMP_G && liveMainL == LAMP_Y;
  end

  always_ff @(posedge masterclk) begin
    if (reset_button) begin
      prevMain           <= 3'b100;
      prevSide           <= 3'b100;
      prevValid          <= 1'b0;
      yellowMainCnt      <= '0;
      yellowSideCnt      <= '0;
      phaseCnt           <= '0;
      fault_onehot       <= 1'b0;
      fault_conflict     <= 1'b0;
      fault_sequence     <= 1'b0;
      fault_yellow_short <= 1'b0;
      fault_timeout      <= 1'b0;
      fault_any          <= 1'b0;
      last_fault_code    <= 3'd0;
      main_green_count   <= '0;
    end else begin
      prevMain           <= mainStreetleds;
      prevSide           <= sideStreetleds;
      prevValid          <= 1'b1;
      yellowMainCnt      <= yellowMainNext;
      yellowSideCnt      <= yellowSideNext;
      phaseCnt           <= phaseNext;
      fault_onehot       <= faultsNext[0];
      fault_conflict     <= faultsNext[1];
      fault_sequence     <= faultsNext[2];
      fault_yellow_short <= faultsNext[3];
      fault_timeout      <= faultsNext[4];
      fault_any          <= |faultsNext;
      last_fault_code    <= codeNext;
      if (greenDone)
        main_green_count <= main_green_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/tlc_light_monitor.md
Name: tlc_light_monitor

Overview:
- Synthesizable checker at the receiving end of the traffic light controller's lamp outputs.
- Samples mainStreetleds and sideStreetleds every clock and decodes each street's lamp state.
- Flags illegal encodings, cross-street conflicts, illegal phase order, short yellow phases and stuck phases with sticky fault bits.
- Sits beside the controller in the top level, or on the bench, as a hardware safety interlock.

Parameters:
MIN_YELLOW_CYCLES, 3, minimum number of consecutive cycles a street must show yellow before it goes red.
MAX_PHASE_CYCLES, 1000, maximum number of cycles the combined {main,side} lamp pattern may stay unchanged.
CNT_W, 16, width of the phase counter and the main-green completion counter.

Ports:
masterclk  input  1  system clock; all logic on the rising edge.
reset_button  input  1  synchronous reset, active-high.
mainStreetleds  input  3  main street lamps: [2]=red, [1]=yellow, [0]=green.
sideStreetleds  input  3  side street lamps, same bit order.
monitor_enable  input  1  1 = checking active.
clear_faults  input  1  1-cycle pulse; clears all sticky faults and last_fault_code.
fault_onehot  output  1  sticky; a street showed an encoding other than 100, 010 or 001.
fault_conflict  output  1  sticky; both streets were non-red at the same time.
fault_sequence  output  1  sticky; a street made an illegal transition.
fault_yellow_short  output  1  sticky; yellow was held fewer than MIN_YELLOW_CYCLES cycles.
fault_timeout  output  1  sticky; the pattern stayed unchanged longer than MAX_PHASE_CYCLES cycles.
fault_any  output  1  OR of the five fault bits; registered.
last_fault_code  output  3  code of the most recent newly detected fault (see Behaviour).
main_green_count  output  CNT_W  number of completed main-street green phases.

Behaviour:
- Reset (reset_button=1 at a rising edge):
  - All fault bits, fault_any, last_fault_code, main_green_count and counters go to 0.
  - The prev-sample registers go to 100/100 and prev_valid goes to 0.
  - Reset wins over every other input in that cycle.
- Decode per street: 100=R, 010=Y, 001=G; any other value = ILLEGAL.
- Sampling and latency:
  - The live inputs are compared against prev_main/prev_side registered at the previous edge.
  - Fault bits update at the same edge, so a flag is visible 1 cycle after the offending input is sampled.
  - prev registers load the live inputs every cycle, including while monitor_enable=0.
  - prev_valid goes to 1 after the first post-reset sample.
- Checks, evaluated only when monitor_enable=1 (enable low sets no faults):
  - onehot: either live street is ILLEGAL.
  - conflict: both streets decode legal and neither is R.
  - sequence (only when prev_valid=1 and prev and live are both legal): allowed transitions are hold, R->G, G->Y and Y->R. Anything else sets the fault, e.g. G->R, Y->G or R->Y.
  - yellow_short: each street has a yellow dwell counter.
    - The counter loads 1 on entry to Y and increments while Y is held, saturating at MIN_YELLOW_CYCLES.
    - On a Y->R transition, a count below MIN_YELLOW_CYCLES sets the fault.
    - The counter clears when the street is not Y or when monitor_enable=0.
  - timeout: a phase counter clears whenever {main,side} differs from prev and otherwise increments, saturating at its maximum. The fault sets when the count exceeds MAX_PHASE_CYCLES. The counter clears while monitor_enable=0.
- Stickiness:
  - Fault bits hold until clear_faults or reset.
  - If clear_faults and a new detection occur in the same cycle, the new detection wins: that bit is set and the others are cleared.
- last_fault_code: 0=none, 1=onehot, 2=conflict, 3=sequence, 4=yellow_short, 5=timeout.
  - Updated only in cycles with at least one new detection.
  - If several faults are detected in the same cycle, the lowest code takes priority.
  - Cleared to 0 by clear_faults unless a new detection occurs in that cycle.
- main_green_count increments on a main-street G->Y transition while enabled, and wraps modulo 2^CNT_W. clear_faults does not affect it.
- fault_any is the OR of the next-state values of the fault bits, so it is aligned with them.

Test Plan:
- Legal sequence, with monitor_enable=1 and MIN_YELLOW_CYCLES=3:
  - main R->G(10 cycles)->Y(3)->R while side holds R, then side G->Y(3)->R while main holds R.
  - Required: all faults stay 0 and main_green_count=1.
- Main steps 001 -> 011 for one cycle -> fault_onehot=1 and last_fault_code=1 one cycle later; all other faults stay 0.
- Main=001 with side=001 in the same cycle -> fault_conflict=1, last_fault_code=2, fault_any=1.
- Main G->R directly -> fault_sequence=1, code=3. Separately, main Y held 2 cycles then R -> fault_yellow_short=1, code=4.
- Timeout with MAX_PHASE_CYCLES=8: hold pattern 100/001 for 10 cycles -> fault_timeout rises after the 9th unchanged cycle, code=5. Then pulse clear_faults -> all faults 0 and code 0.
- Clear versus reset:
  - clear_faults in the same cycle as a conflict -> fault_conflict=1 and the other previously set bits are cleared.
  - reset_button mid-yellow -> all outputs 0, and the first post-reset sample raises no sequence fault.
